// File: rtl/msg_padder.sv
// Streaming message padder: passes message words, then appends pad, zero and length words to fill whole blocks.
// Optional MSG_PADDER_EXT_LEN_EN: adds msg_len port; the length word carries that sampled value verbatim.
module msg_padder #(
    parameter int W         = 64,
    parameter int BLK_WORDS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef MSG_PADDER_EXT_LEN_EN
    input  logic [W-1:0] msg_len,
`endif
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         out_blk_end,
    output logic         busy
);

    localparam int PW = $clog2(BLK_WORDS);
    localparam logic [PW-1:0] LP_SLOT_LAST = PW'(BLK_WORDS - 1);
    localparam logic [PW-1:0] LP_SLOT_PRE  = PW'(BLK_WORDS - 2);
    localparam logic [W-1:0]  LP_W         = W'(W);
    localparam logic [W-1:0]  LP_PAD       = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_MSG,
        S_PAD,
        S_ZERO,
        S_LEN
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_pos;
    logic [W-1:0]  r_wcnt;
    logic [W-1:0]  w_len;
    logic          w_xfer;

    assign w_xfer = out_valid & out_ready;

`ifdef MSG_PADDER_EXT_LEN_EN
    logic [W-1:0] r_msg_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msg_len <= '0;
        end else if (r_state == S_MSG && w_xfer && in_last) begin
            r_msg_len <= msg_len;
        end
    end

    assign w_len = r_msg_len;
`else
    assign w_len = r_wcnt * LP_W;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_MSG;
            r_pos   <= '0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_pos <= (r_state == S_LEN || r_pos == LP_SLOT_LAST) ? '0 : r_pos + 1'b1;
                if (r_state == S_MSG) begin
                    r_wcnt <= r_wcnt + 1'b1;
                end else if (r_state == S_LEN) begin
                    r_wcnt <= '0;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        out_data    = '0;
        out_valid   = 1'b1;
        out_last    = 1'b0;
        in_ready    = 1'b0;
        unique case (r_state)
            S_MSG: begin
                out_data  = in_data;
                out_valid = in_valid;
                in_ready  = out_ready;
                if (w_xfer && in_last) begin
                    w_state_nxt = S_PAD;
                end
            end
            S_PAD: begin
                out_data = LP_PAD;
                // Pad in the last slot leaves no room for length: a full zero block follows.
                if (w_xfer) begin
                    w_state_nxt = (r_pos == LP_SLOT_PRE) ? S_LEN : S_ZERO;
                end
            end
            S_ZERO: begin
                if (w_xfer && r_pos == LP_SLOT_PRE) begin
                    w_state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                out_data = w_len;
                out_last = 1'b1;
                if (w_xfer) begin
                    w_state_nxt = S_MSG;
                end
            end
            default: w_state_nxt = S_MSG;
        endcase
    end

    assign out_blk_end = out_valid & (r_pos == LP_SLOT_LAST);
    assign busy        = (r_state != S_MSG) | (r_wcnt != '0);

endmodule

// File: tb/tb_msg_padder.sv
// Directed self-checking bench for msg_padder (W=64, BLK_WORDS=16).
module tb_msg_padder;

    localparam int W   = 64;
    localparam int BLK = 16;
    localparam logic [W-1:0] PAD = 64'h8000_0000_0000_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         out_blk_end;
    logic         busy;
`ifdef MSG_PADDER_EXT_LEN_EN
    logic [W-1:0] msg_len;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    msg_padder #(.W(W), .BLK_WORDS(BLK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef MSG_PADDER_EXT_LEN_EN
        .msg_len    (msg_len),
`endif
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_blk_end(out_blk_end),
        .busy       (busy)
    );

    // flags = {out_valid, in_ready, out_last, out_blk_end, busy}
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef MSG_PADDER_EXT_LEN_EN
        msg_len = '0;
`endif
        #1;
        n_checks++;
        if ({out_valid, out_last, out_blk_end, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset: {valid,last,blk_end,busy}=%b expected 0000",
                     {out_valid, out_last, out_blk_end, busy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_msg(input string name, input int n, input int zeros,
                            input logic [W-1:0] len, input int total);
        int idx;
        logic [W-1:0] d;
        idx = 0;
`ifdef MSG_PADDER_EXT_LEN_EN
        msg_len = len;
`endif
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d = 64'hA5A5_0000_0000_0000 | (64'(n) << 16) | 64'(i);
            in_valid = 1'b1; in_data = d; in_last = (i == n - 1);
            #1;
            n_checks++;
            if ({out_data, out_valid, in_ready, out_last, out_blk_end, busy} !==
                {d, 3'b110, (idx % BLK == BLK - 1), (i != 0)}) begin
                n_fail++;
                $display("FAIL %s msg word %0d: data=%h flags=%b expected data=%h flags=%b", name, idx,
                         out_data, {out_valid, in_ready, out_last, out_blk_end, busy},
                         d, {3'b110, (idx % BLK == BLK - 1), (i != 0)});
            end
            idx++;
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_data = '1;
`ifdef MSG_PADDER_EXT_LEN_EN
        msg_len = ~len;
`endif
        #1;
        n_checks++;
        if ({out_data, out_valid, in_ready, out_last, out_blk_end, busy} !==
            {PAD, 3'b100, (idx % BLK == BLK - 1), 1'b1}) begin
            n_fail++;
            $display("FAIL %s pad word %0d: data=%h flags=%b expected data=%h flags=%b", name, idx,
                     out_data, {out_valid, in_ready, out_last, out_blk_end, busy},
                     PAD, {3'b100, (idx % BLK == BLK - 1), 1'b1});
        end
        idx++;
        for (int z = 0; z < zeros; z++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({out_data, out_valid, in_ready, out_last, out_blk_end, busy} !==
                {64'h0, 3'b100, (idx % BLK == BLK - 1), 1'b1}) begin
                n_fail++;
                $display("FAIL %s zero word %0d: data=%h flags=%b expected data=0 flags=%b", name, idx,
                         out_data, {out_valid, in_ready, out_last, out_blk_end, busy},
                         {3'b100, (idx % BLK == BLK - 1), 1'b1});
            end
            idx++;
        end
        @(negedge clk); #1;
        n_checks++;
        if ({out_data, out_valid, in_ready, out_last, out_blk_end, busy} !== {len, 5'b10111}) begin
            n_fail++;
            $display("FAIL %s len word %0d: data=%h flags=%b expected data=%h flags=10111", name, idx,
                     out_data, {out_valid, in_ready, out_last, out_blk_end, busy}, len);
        end
        idx++;
        n_checks++;
        if (idx !== total) begin
            n_fail++;
            $display("FAIL %s word count: got %0d expected %0d", name, idx, total);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({out_valid, out_last, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s idle after len: {valid,last,busy}=%b expected 000", name,
                     {out_valid, out_last, busy});
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] exp_w [13];
        exp_w[0] = PAD;
        for (int k = 1; k < 12; k++) exp_w[k] = '0;
        exp_w[12] = 64'h0000_0000_0000_00C0;
`ifdef MSG_PADDER_EXT_LEN_EN
        msg_len = 64'hC0;
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 64'(i + 7); in_last = (i == 2);
            #1;
            n_checks++;
            if ({out_data, out_valid, in_ready} !== {64'(i + 7), 2'b11}) begin
                n_fail++;
                $display("FAIL stall msg word %0d: data=%h valid=%b in_ready=%b", i,
                         out_data, out_valid, in_ready);
            end
        end
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; in_last = 1'b0; in_data = 64'hDEAD_BEEF_0000_0000;
            #1;
            n_checks++;
            if ({out_data, out_valid, in_ready, out_last} !== {exp_w[k], 2'b10, (k == 12)}) begin
                n_fail++;
                $display("FAIL stall held word %0d: data=%h flags=%b expected data=%h flags=%b", k,
                         out_data, {out_valid, in_ready, out_last}, exp_w[k], {2'b10, (k == 12)});
            end
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b0;
            #1;
            n_checks++;
            if ({out_data, out_valid, in_ready, out_last, out_blk_end} !==
                {exp_w[k], 2'b10, (k == 12), ((k + 3) % BLK == BLK - 1)}) begin
                n_fail++;
                $display("FAIL stall released word %0d: data=%h flags=%b expected data=%h flags=%b", k,
                         out_data, {out_valid, in_ready, out_last, out_blk_end},
                         exp_w[k], {2'b10, (k == 12), ((k + 3) % BLK == BLK - 1)});
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL stall idle: {valid,busy}=%b expected 00", {out_valid, busy});
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 64'(i); in_last = (i == 2);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({out_data, out_valid, busy} !== {64'h0, 2'b11}) begin
            n_fail++;
            $display("FAIL rst_mid precondition: data=%h valid=%b busy=%b expected zero word, busy",
                     out_data, out_valid, busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_last, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid async: {valid,last,busy}=%b expected 000", {out_valid, out_last, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
`ifdef MSG_PADDER_EXT_LEN_EN
        test_msg("rst_1word", 1, 13, 64'h123, 16);
`else
        test_msg("rst_1word", 1, 13, 64'h40, 16);
`endif
    endtask

    initial begin
        test_reset();
        test_msg("msg3", 3, 11, 64'h0C0, 16);
        test_msg("msg14", 14, 0, 64'h380, 16);
        test_msg("msg15", 15, 15, 64'h3C0, 32);
        test_msg("msg16", 16, 14, 64'h400, 32);
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within 200000 time units");
        $fatal(1);
    end

endmodule
